inst_rom_loader: RTL and testbench

- Instruction memory that sits directly upstream of the CPU core's instruction-fetch port.
- Combinationally returns the instruction word for the core's `rom_addr`/`rom_ce` request.
- Contains a byte-stream program loader (UART-style byte source) that fills the memory with big-endian 32-bit words.
- Holds the core in reset while a load is in progress, so new programs can be loaded without resynthesis.

---
 rtl/inst_rom_loader.sv | 121 ++++++++++++
 tb/tb_inst_rom_loader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_loader.sv
// Instruction ROM for the core's fetch port, refilled at run time from a byte stream.
// Stream format: 16-bit big-endian word count, then that many big-endian 32-bit words.
module inst_rom_loader #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce,
    input  logic [31:0]       rom_addr,
    output logic [31:0]       rom_data,
    input  logic              load_start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              cpu_rst_o,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  words_loaded
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, FIN} state_t;

    state_t             state;
    logic [31:0]        mem [DEPTH];
    logic [7:0]         count_hi;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   hdr_cnt;
    logic [ADDR_W:0]    wr_ptr;      // extra MSB marks "past the end": saturates, never wraps
    logic [1:0]         byte_idx;
    logic [23:0]        asm_bytes;
    logic               wr_en;
    logic [31:0]        wr_word;
    logic               unused_addr;

    assign hdr_cnt = CNT_W'({count_hi, byte_data});
    assign wr_word = {asm_bytes, byte_data};
    assign wr_en   = !rst && (state == DATA) && byte_valid && (byte_idx == 2'd3)
                     && !wr_ptr[ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[ADDR_W-1:0]] <= wr_word;
    end

    // Read-before-write: a same-cycle write to the fetched word is visible only after the edge.
    assign rom_data    = rom_ce ? mem[rom_addr[ADDR_W+1:2]] : 32'h0;
    assign unused_addr = ^{rom_addr[31:ADDR_W+2], rom_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            cpu_rst_o    <= 1'b1;
            words_loaded <= '0;
            count_hi     <= '0;
            count        <= '0;
            wr_ptr       <= '0;
            byte_idx     <= '0;
            asm_bytes    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cpu_rst_o <= 1'b0;
                    if (load_start) begin
                        state        <= LEN_HI;
                        busy         <= 1'b1;
                        cpu_rst_o    <= 1'b1;
                        words_loaded <= '0;
                    end
                end
                LEN_HI: begin
                    if (byte_valid) begin
                        count_hi <= byte_data;
                        state    <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (byte_valid) begin
                        count    <= hdr_cnt;
                        wr_ptr   <= '0;
                        byte_idx <= '0;
                        if (hdr_cnt == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (byte_valid) begin
                        byte_idx  <= byte_idx + 2'd1;
                        asm_bytes <= {asm_bytes[15:0], byte_data};
                        if (byte_idx == 2'd3) begin
                            words_loaded <= words_loaded + CNT_W'(1);
                            if (!wr_ptr[ADDR_W])
                                wr_ptr <= wr_ptr + 1'b1;
                            if (words_loaded + CNT_W'(1) == count) begin
                                state <= FIN;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                FIN: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cpu_rst_o <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cpu_rst_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_inst_rom_loader.sv
// Scoreboard bench for inst_rom_loader on a 4-word memory so overflow and aliasing are reachable.
module tb_inst_rom_loader;
    localparam int ADDR_W = 2;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst;
    logic              rom_ce;
    logic [31:0]       rom_addr;
    logic [31:0]       rom_data;
    logic              load_start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              cpu_rst_o;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  words_loaded;

    inst_rom_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .rom_ce       (rom_ce),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .load_start   (load_start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .cpu_rst_o    (cpu_rst_o),
        .busy         (busy),
        .done         (done),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    logic [31:0] model_mem [4];
    logic [31:0] load_q [$];
    logic [31:0] rd_q [$];
    logic [31:0] wl_q [$];

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit ls);
        byte_valid = 1'b0;
        repeat (gap) tick();
        byte_valid = 1'b1;
        byte_data  = b;
        load_start = ls;
        tick();
        byte_valid = 1'b0;
        load_start = 1'b0;
        chk("busy_ld", {31'b0, busy}, 32'd1);
        chk("cpu_rst_ld", {31'b0, cpu_rst_o}, 32'd1);
    endtask

    task automatic rd(input logic [31:0] a, input bit ce);
        rom_ce   = ce;
        rom_addr = a;
        rd_q.push_back(ce ? model_mem[a[3:2]] : 32'h0);
        #1;
        chk("rom_data", rom_data, rd_q.pop_front());
        rom_ce = 1'b0;
    endtask

    // Drives a complete load of load_q; gaps are random up to gapmax.
    task automatic run_load(input int gapmax, input bit spurious);
        int          n;
        int          d0;
        logic [15:0] hdr;
        logic [31:0] w;
        n   = load_q.size();
        hdr = 16'(n);
        d0  = done_cnt;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("busy_start", {31'b0, busy}, 32'd1);
        chk("cpu_rst_start", {31'b0, cpu_rst_o}, 32'd1);
        wl_q.push_back(32'(n));
        send_byte(hdr[15:8], $urandom_range(gapmax, 0), 1'b0);
        send_byte(hdr[7:0],  $urandom_range(gapmax, 0), 1'b0);
        for (int i = 0; i < n; i++) begin
            w = load_q[i];
            for (int b = 0; b < 4; b++)
                send_byte(w[31-8*b -: 8], $urandom_range(gapmax, 0), spurious && i == 0 && b == 1);
            if (i < 4) model_mem[i] = w;
        end
        for (int c = 0; c < 8 && done !== 1'b1; c++) tick();
        chk("done_seen", {31'b0, done}, 32'd1);
        chk("words_loaded", 32'(words_loaded), wl_q.pop_front());
        chk("cpu_rst_fin", {31'b0, cpu_rst_o}, 32'd1);
        tick();
        chk("done_clr", {31'b0, done}, 32'd0);
        chk("busy_idle", {31'b0, busy}, 32'd0);
        chk("cpu_rst_rel", {31'b0, cpu_rst_o}, 32'd0);
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        rst = 1'b1; rom_ce = 1'b0; rom_addr = '0;
        load_start = 1'b0; byte_valid = 1'b0; byte_data = '0;
        for (int i = 0; i < 4; i++) model_mem[i] = '0;

        tick(); tick();
        chk("rst_cpu_rst", {31'b0, cpu_rst_o}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_wl", 32'(words_loaded), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_cpu_rst", {31'b0, cpu_rst_o}, 32'd0);

        // back-to-back two-word program
        load_q = '{32'h34010010, 32'h3C02ABCD};
        run_load(0, 1'b0);
        rd(32'h4, 1'b1);
        rd(32'h0, 1'b1);
        rd(32'h4, 1'b0);

        // stray bytes while idle must not load anything
        for (int i = 0; i < 4; i++) begin
            byte_valid = 1'b1; byte_data = 8'hA5 + 8'(i);
            tick();
        end
        byte_valid = 1'b0;
        chk("idle_bytes_busy", {31'b0, busy}, 32'd0);
        rd(32'h0, 1'b1);
        rd(32'h4, 1'b1);

        // gapped stream with a spurious load_start mid-data
        load_q = '{32'hA1B2C3D4, 32'h0F1E2D3C};
        run_load(5, 1'b1);
        rd(32'h0, 1'b1);
        rd(32'h4, 1'b1);

        // zero-length program
        load_q = '{};
        run_load(2, 1'b0);
        rd(32'h0, 1'b1);
        rd(32'h4, 1'b1);

        // reset mid-load: one full word plus two bytes
        load_start = 1'b1; tick(); load_start = 1'b0;
        send_byte(8'h00, 0, 1'b0); send_byte(8'h02, 0, 1'b0);
        send_byte(8'h0B, 0, 1'b0); send_byte(8'hAD, 0, 1'b0);
        send_byte(8'hF0, 1, 1'b0); send_byte(8'h0D, 0, 1'b0);
        model_mem[0] = 32'h0BADF00D;
        send_byte(8'h11, 0, 1'b0); send_byte(8'h22, 0, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_cpu_rst", {31'b0, cpu_rst_o}, 32'd1);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_wl", 32'(words_loaded), 32'd0);
        tick();
        chk("abort_rel", {31'b0, cpu_rst_o}, 32'd0);
        rd(32'h0, 1'b1);
        rd(32'h4, 1'b1);
        load_q = '{32'hDEADBEEF};
        run_load(1, 1'b0);
        rd(32'h0, 1'b1);
        rd(32'h4, 1'b1);

        // five words into a four-word memory: last word dropped, pointer must not wrap
        load_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
        run_load(1, 1'b0);
        rd(32'h0, 1'b1);
        rd(32'h4, 1'b1);
        rd(32'h8, 1'b1);
        rd(32'hC, 1'b1);
        rd(32'h0000_0013, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
